// File: rtl/flt2int_pkg.sv
// Shared types and constants for the half-precision float to sign-magnitude
// integer converter.
package flt2int_pkg;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int SIG_W = MAN_W + 1;
   localparam int MAG_W = 15;
   localparam int CNT_W = 4;

   localparam logic [EXP_W-1:0] BIAS      = 5'd15;
   // Exponent at which sig (with its hidden bit) is already an integer.
   localparam logic [EXP_W-1:0] EXP_UNITY = BIAS + 5'(MAN_W);
   // From here up the value is at least 2^15 and cannot fit 15 magnitude bits.
   localparam logic [EXP_W-1:0] EXP_SAT   = 5'd30;
   // At or below this the value is below 0.5 and always rounds to zero.
   localparam logic [EXP_W-1:0] EXP_ZERO  = EXP_UNITY - 5'd12;

   localparam logic [MAG_W-1:0] MAX_MAG = 15'h7FFF;

   typedef enum logic [3:0] {
      IDLE,
      RD_HI,
      RD_LO,
      CLASS,
      SHIFT,
      ROUND,
      WR_HI,
      WR_LO,
      DONE
   } state_t;

   // How the latched exponent sends the conversion through the datapath.
   typedef enum logic [2:0] {
      CLS_SAT,
      CLS_ZERO,
      CLS_UNITY,
      CLS_SHR,
      CLS_SHL
   } cls_t;

   function automatic cls_t classify(input logic [EXP_W-1:0] e);
      cls_t c;
      if (e >= EXP_SAT)
         c = CLS_SAT;
      else if (e <= EXP_ZERO)
         c = CLS_ZERO;
      else if (e == EXP_UNITY)
         c = CLS_UNITY;
      else if (e < EXP_UNITY)
         c = CLS_SHR;
      else
         c = CLS_SHL;
      return c;
   endfunction

endpackage

// File: rtl/flt2int_shifter.sv
// Magnitude register with one-bit-per-cycle shifting, guard/sticky capture
// for right shifts, round-to-nearest-even increment and a shift counter.
module flt2int_shifter
   import flt2int_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [MAG_W-1:0] load_val,
   input  logic [CNT_W-1:0] load_cnt,
   input  logic             shl,
   input  logic             shr,
   input  logic             rnd,
   output logic [MAG_W-1:0] mag,
   output logic             zero
);

   logic             guard;
   logic             sticky;
   logic [CNT_W-1:0] count;
   logic             round_up;

   // Nearest-even: bump when above half, or exactly half with an odd lsb.
   assign round_up = guard & (sticky | mag[0]);

   // Counter holds remaining shifts minus one, so zero marks the last shift.
   assign zero = (count == '0);

   // Magnitude, guard/sticky and count update according to the FSM command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mag    <= '0;
         guard  <= 1'b0;
         sticky <= 1'b0;
         count  <= '0;
      end else if (load) begin
         mag    <= load_val;
         guard  <= 1'b0;
         sticky <= 1'b0;
         count  <= load_cnt;
      end else if (shr) begin
         mag    <= {1'b0, mag[MAG_W-1:1]};
         guard  <= mag[0];
         sticky <= sticky | guard;
         count  <= count - 1'b1;
      end else if (shl) begin
         mag    <= {mag[MAG_W-2:0], 1'b0};
         count  <= count - 1'b1;
      end else if (rnd) begin
         // Largest pre-round value is 32752, so the increment never wraps.
         if (round_up)
            mag <= mag + 1'b1;
      end
   end

endmodule

// File: rtl/flt2int_seq.sv
// Memory-mapped converter: reads a half-precision float as two bytes,
// converts it to a 16-bit sign-magnitude integer with round-to-nearest-even
// and saturation, writes the two result bytes back and then holds done.
module flt2int_seq
   import flt2int_pkg::*;
#(
   parameter logic [7:0] SRC_HI = 8'd5,
   parameter logic [7:0] SRC_LO = 8'd6,
   parameter logic [7:0] DST_HI = 8'd1,
   parameter logic [7:0] DST_LO = 8'd2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data
);

   state_t           state;
   state_t           state_nxt;

   logic [7:0]       hi_byte;
   logic [7:0]       lo_byte;
   logic             left_dir;

   logic [EXP_W-1:0] exp_f;
   logic [SIG_W-1:0] sig;
   logic             sign;
   cls_t             cls;

   logic             load;
   logic             shl;
   logic             shr;
   logic             rnd;
   logic [MAG_W-1:0] load_val;
   logic [CNT_W-1:0] load_cnt;
   logic [MAG_W-1:0] mag;
   logic             zero;

   assign sign  = hi_byte[7];
   assign exp_f = hi_byte[6:2];
   assign sig   = {1'b1, hi_byte[1:0], lo_byte};
   assign cls   = classify(exp_f);

   // Initial magnitude and shift count chosen when the float is classified.
   always_comb begin
      load_val = '0;
      load_cnt = '0;
      case (cls)
         CLS_SAT:   load_val = MAX_MAG;
         CLS_ZERO:  load_val = '0;
         CLS_UNITY: load_val = MAG_W'(sig);
         CLS_SHR: begin
            load_val = MAG_W'(sig);
            load_cnt = CNT_W'(EXP_UNITY - exp_f - 5'd1);
         end
         CLS_SHL: begin
            load_val = MAG_W'(sig);
            load_cnt = CNT_W'(exp_f - EXP_UNITY - 5'd1);
         end
         default: load_val = '0;
      endcase
   end

   // Source byte latches and shift direction, captured in their own states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_byte  <= '0;
         lo_byte  <= '0;
         left_dir <= 1'b0;
      end else begin
         if (state == RD_HI)
            hi_byte <= mem_rd_data;
         if (state == RD_LO)
            lo_byte <= mem_rd_data;
         if (state == CLASS)
            left_dir <= (cls == CLS_SHL);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; start is only honoured from IDLE and DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RD_HI;
         RD_HI:   state_nxt = RD_LO;
         RD_LO:   state_nxt = CLASS;
         CLASS: begin
            case (cls)
               CLS_SAT,
               CLS_ZERO:  state_nxt = WR_HI;
               CLS_UNITY: state_nxt = ROUND;
               default:   state_nxt = SHIFT;
            endcase
         end
         SHIFT:   if (zero) state_nxt = ROUND;
         ROUND:   state_nxt = WR_HI;
         WR_HI:   state_nxt = WR_LO;
         WR_LO:   state_nxt = DONE;
         DONE:    if (start) state_nxt = RD_HI;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory bus, done flag and datapath commands decoded from the state.
   always_comb begin
      done        = 1'b0;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      load        = 1'b0;
      shl         = 1'b0;
      shr         = 1'b0;
      rnd         = 1'b0;
      case (state)
         RD_HI: mem_addr = SRC_HI;
         RD_LO: mem_addr = SRC_LO;
         CLASS: load = 1'b1;
         SHIFT: begin
            shl = left_dir;
            shr = ~left_dir;
         end
         ROUND: rnd = 1'b1;
         WR_HI: begin
            mem_addr    = DST_HI;
            mem_wr_en   = 1'b1;
            mem_wr_data = {sign, mag[14:8]};
         end
         WR_LO: begin
            mem_addr    = DST_LO;
            mem_wr_en   = 1'b1;
            mem_wr_data = mag[7:0];
         end
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   flt2int_shifter u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .load_cnt (load_cnt),
      .shl      (shl),
      .shr      (shr),
      .rnd      (rnd),
      .mag      (mag),
      .zero     (zero)
   );

endmodule

// File: tb/tb_flt2int_seq.sv
// Bench for flt2int_seq: byte memory model, directed vector table, held-start
// and mid-conversion reset sequences, and randomized floats against a model.
module tb_flt2int_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   logic [7:0] mem [0:255];
   logic       poke_en;
   logic [7:0] poke_addr;
   logic [7:0] poke_data;
   int         wr_total;

   int         n_checks;
   int         n_fail;

   typedef struct {
      logic [15:0] f;
      logic [15:0] res;
      int          lat;
   } vec_t;

   vec_t vecs [12];

   flt2int_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_addr];

   // Memory: DUT writes take priority; bench pokes only happen while idle.
   initial wr_total = 0;
   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr] <= mem_wr_data;
         wr_total      <= wr_total + 1;
      end else if (poke_en) begin
         mem[poke_addr] <= poke_data;
      end
   end

   // Reference: exact value sig*2^-k rounded half-to-even, then clamped.
   function automatic logic [15:0] ref_conv(input logic [15:0] f);
      int     e;
      int     k;
      longint sig;
      longint q;
      longint rem;
      longint half;
      longint m;
      logic [63:0] mb;
      e = int'(f[14:10]);
      if (e == 31) begin
         m = 32767;
      end else begin
         if (e == 0) begin
            sig = longint'(f[9:0]);
            k   = 24;
         end else begin
            sig = 1024 + longint'(f[9:0]);
            k   = 25 - e;
         end
         if (k <= 0) begin
            m = sig <<< (-k);
         end else begin
            q    = sig >>> k;
            rem  = sig - (q <<< k);
            half = 64'sd1 <<< (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1))
               q = q + 1;
            m = q;
         end
         if (m > 32767)
            m = 32767;
      end
      mb = 64'(m);
      return {f[15], mb[14:0]};
   endfunction

   // Cycles from the start edge to done, from the exponent alone.
   function automatic int ref_lat(input logic [15:0] f);
      int e;
      e = int'(f[14:10]);
      if (e >= 30 || e <= 13)
         return 6;
      else if (e >= 25)
         return 7 + (e - 25);
      else
         return 7 + (25 - e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clk);
      poke_en   = 1'b0;
   endtask

   task automatic run_conv(input logic [15:0] f, output logic [15:0] res,
                           output int cyc, output int wrs);
      int w0;
      poke(8'd5, f[15:8]);
      poke(8'd6, f[7:0]);
      poke(8'd1, 8'hA5);
      poke(8'd2, 8'h5A);
      w0 = wr_total;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      res = {mem[1], mem[2]};
      wrs = wr_total - w0;
   endtask

   initial begin
      logic [15:0] res;
      logic [15:0] f;
      int          cyc;
      int          wrs;
      int          w0;
      int          w_prev;
      int          guard_cnt;

      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      poke_en   = 1'b0;
      poke_addr = '0;
      poke_data = '0;

      vecs[0]  = '{16'h3C00, 16'h0001, 17};
      vecs[1]  = '{16'h3800, 16'h0000, 18};
      vecs[2]  = '{16'h3E00, 16'h0002, 17};
      vecs[3]  = '{16'h4100, 16'h0002, 16};
      vecs[4]  = '{16'h7800, 16'h7FFF, 6};
      vecs[5]  = '{16'hFC00, 16'hFFFF, 6};
      vecs[6]  = '{16'h75FF, 16'h5FF0, 11};
      vecs[7]  = '{16'h4A00, 16'h000C, 14};
      vecs[8]  = '{16'h8000, 16'h8000, 6};
      vecs[9]  = '{16'h0001, 16'h0000, 6};
      vecs[10] = '{16'h6400, 16'h0400, 7};
      vecs[11] = '{16'hBC00, 16'h8001, 17};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("reset done", 32'(done), 32'h0);
      check("reset mem_addr", 32'(mem_addr), 32'h0);
      check("reset mem_wr_en", 32'(mem_wr_en), 32'h0);
      check("reset mem_wr_data", 32'(mem_wr_data), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         run_conv(vecs[i].f, res, cyc, wrs);
         check($sformatf("vec%0d result f=%04h", i, vecs[i].f), 32'(res), 32'(vecs[i].res));
         check($sformatf("vec%0d latency f=%04h", i, vecs[i].f), 32'(cyc), 32'(vecs[i].lat));
         check($sformatf("vec%0d writes", i), 32'(wrs), 32'd2);
      end

      // start held high: one conversion per DONE visit, two writes each
      poke(8'd5, 8'h3E);
      poke(8'd6, 8'h00);
      poke(8'd1, 8'hA5);
      poke(8'd2, 8'h5A);
      w_prev = wr_total;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         guard_cnt = 0;
         @(posedge clk);
         #1;
         while (!done && guard_cnt < 40) begin
            @(posedge clk);
            #1;
            guard_cnt++;
         end
         check($sformatf("held start done reached %0d", k), 32'(done), 32'h1);
         check($sformatf("held start result %0d", k), 32'({mem[1], mem[2]}), 32'h0002);
         check($sformatf("held start writes %0d", k), 32'(wr_total - w_prev), 32'd2);
         w_prev = wr_total;
         @(posedge clk);
         #1;
         check($sformatf("held start done drops %0d", k), 32'(done), 32'h0);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      check("held start release done", 32'(done), 32'h1);
      check("held start release writes", 32'(wr_total - w_prev), 32'd2);

      // Reset during SHIFT aborts cleanly
      poke(8'd5, 8'h3C);
      poke(8'd6, 8'h00);
      poke(8'd1, 8'hA5);
      poke(8'd2, 8'h5A);
      w0 = wr_total;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort mem_addr", 32'(mem_addr), 32'h0);
      check("abort mem_wr_en", 32'(mem_wr_en), 32'h0);
      check("abort done", 32'(done), 32'h0);
      @(posedge clk);
      #1;
      check("abort mem_wr_data", 32'(mem_wr_data), 32'h0);
      check("abort held done", 32'(done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("abort dst untouched", 32'({mem[1], mem[2]}), 32'hA55A);
      check("abort no writes", 32'(wr_total - w0), 32'd0);
      check("abort stays idle", 32'(done), 32'h0);
      run_conv(16'h4A00, res, cyc, wrs);
      check("after abort result", 32'(res), 32'h000C);
      check("after abort latency", 32'(cyc), 32'd14);

      // Randomized floats against the reference
      for (int i = 0; i < 150; i++) begin
         f = 16'($urandom);
         if (i % 2 == 1)
            f[14:10] = 5'($urandom_range(31, 12));
         run_conv(f, res, cyc, wrs);
         check($sformatf("rand result f=%04h", f), 32'(res), 32'(ref_conv(f)));
         check($sformatf("rand latency f=%04h", f), 32'(cyc), 32'(ref_lat(f)));
         check($sformatf("rand writes f=%04h", f), 32'(wrs), 32'd2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
